proc_run_monitor: RTL and testbench
===================================

// Module: proc_run_monitor
// PURPOSE
//   Synthesisable run/halt monitor for the pipelined Processor. Watches the fetched instruction
//   word for a halt sentinel, then waits a drain window so in-flight instructions retire, and
//   flags completion or timeout. Traces every register writeback into a FIFO read over valid/ready.
//   Sits beside the Processor in both simulation and FPGA builds; feeds a trace dumper or UART bridge.
// PARAMETERS
//   DBITS          32            data / PC / instruction width
//   REG_BITS       4             register index width (16 regs)
//   HALT_WORD      32'h0000DEAD  instruction word that starts the drain window
//   DRAIN_CYCLES   22            edges from halt detection to DONE (0 = immediate DONE)
//   TIMEOUT_CYCLES 0             RUN-state cycle limit; 0 disables timeout
//   TRACE_DEPTH    16            trace FIFO entries; power of two, >= 2
//   CNT_BITS       32            width of cycle/inst/drop counters
// PORTS
//   clk            in   1              system clock, all state on rising edge
//   reset          in   1              asynchronous, active-high; clears all state
//   enable         in   1              IDLE->RUN start request
//   clear          in   1              synchronous return to IDLE, clears counters/FIFO/flags
//   inst_valid     in   1              inst_word_in/pc_in are a real fetched instruction
//   inst_word_in   in   DBITS          fetched instruction word
//   pc_in          in   DBITS          PC of the writeback instruction
//   wb_en          in   1              register writeback this cycle
//   wb_reg         in   REG_BITS       destination register index
//   wb_data        in   DBITS          value written
//   trace_valid    out  1              FIFO head valid
//   trace_ready    in   1              consumer accepts head when trace_valid=1
//   trace_pc       out  DBITS          head: PC
//   trace_reg      out  REG_BITS       head: register index
//   trace_data     out  DBITS          head: data
//   trace_overflow out  1              sticky: at least one writeback dropped
//   drop_count     out  CNT_BITS       dropped writebacks, saturating
//   cycle_count    out  CNT_BITS       edges spent in RUN+DRAIN, saturating
//   inst_count     out  CNT_BITS       inst_valid edges in RUN+DRAIN, saturating
//   state_out      out  2              0=IDLE 1=RUN 2=DRAIN 3=DONE
//   done           out  1              1 in DONE
//   timeout        out  1              sticky: DONE reached via timeout, not halt
// BEHAVIOUR
//   Reset (async, any time incl. mid-DRAIN): state IDLE, FIFO empty, all outputs 0.
//   clear: synchronous, same effect as reset; has priority over every other input.
//   IDLE: enable=1 -> RUN next edge; counters hold 0; writebacks ignored.
//   RUN: cycle_count+1 per edge. Halt = inst_valid && inst_word_in==HALT_WORD:
//     DRAIN_CYCLES==0 -> DONE; else drain_cnt<=DRAIN_CYCLES, -> DRAIN.
//     Timeout: TIMEOUT_CYCLES!=0 && cycle_count==TIMEOUT_CYCLES-1 -> DONE, timeout<=1.
//     Halt and timeout same edge: halt wins, timeout stays 0.
//   DRAIN: cycle_count+1 per edge; drain_cnt==1 -> DONE, else drain_cnt-1. Further
//     HALT_WORDs ignored (no restart). No timeout in DRAIN.
//   DONE: sticky until reset/clear; counters frozen; enable ignored; FIFO still drains.
//   All counters saturate at 2^CNT_BITS-1, never wrap.
//   Trace FIFO: push {pc_in,wb_reg,wb_data} when wb_en in RUN or DRAIN (incl. the edge
//     leaving DRAIN). Pop when trace_valid&&trace_ready. Push-to-trace_valid latency 1 edge,
//     no bypass. Head fields stable while trace_valid&&!trace_ready.
//   Full: push with simultaneous pop accepted; push without pop dropped, trace_overflow<=1,
//     drop_count+1. Empty: trace_valid=0, pop ignored; head fields hold last value.
//   Pointers log2(TRACE_DEPTH) bits + 1 wrap bit; full/empty from wrap bit compare.
// TESTING
//   1 enable, HALT_WORD at RUN cycle 10, DRAIN_CYCLES=22 -> done exactly 22 edges later, timeout=0.
//   2 TIMEOUT_CYCLES=50, no halt -> DONE after cycle_count=49 edge, timeout=1; halt on that edge -> timeout=0.
//   3 20 writebacks, trace_ready=0, TRACE_DEPTH=16 -> 16 entries in order, drop_count=4, overflow=1.
//   4 full FIFO, wb_en and pop same edge -> entry accepted, count stays 16, no drop.
//   5 reset asserted mid-DRAIN (async, between edges) -> state_out=0, outputs 0 at once.
//   6 DRAIN_CYCLES=0 halt -> DONE next edge; second HALT_WORD in DRAIN -> drain not restarted.

Source files
------------

// File: rtl/proc_run_monitor.sv
// Run/halt monitor beside the pipelined processor: detects the halt sentinel, waits out the
// drain window, flags done/timeout, and traces every register writeback into a small FIFO.
module proc_run_monitor #(
   parameter int                DBITS          = 32,
   parameter int                REG_BITS       = 4,
   parameter logic [DBITS-1:0]  HALT_WORD      = 32'h0000DEAD,
   parameter int                DRAIN_CYCLES   = 22,
   parameter int                TIMEOUT_CYCLES = 0,
   parameter int                TRACE_DEPTH    = 16,
   parameter int                CNT_BITS       = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                clear,
   input  logic                inst_valid,
   input  logic [DBITS-1:0]    inst_word_in,
   input  logic [DBITS-1:0]    pc_in,
   input  logic                wb_en,
   input  logic [REG_BITS-1:0] wb_reg,
   input  logic [DBITS-1:0]    wb_data,
   output logic                trace_valid,
   input  logic                trace_ready,
   output logic [DBITS-1:0]    trace_pc,
   output logic [REG_BITS-1:0] trace_reg,
   output logic [DBITS-1:0]    trace_data,
   output logic                trace_overflow,
   output logic [CNT_BITS-1:0] drop_count,
   output logic [CNT_BITS-1:0] cycle_count,
   output logic [CNT_BITS-1:0] inst_count,
   output logic [1:0]          state_out,
   output logic                done,
   output logic                timeout
);

   localparam int AW = $clog2(TRACE_DEPTH);
   localparam int EW = DBITS + REG_BITS + DBITS;
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

   localparam logic [CNT_BITS-1:0] CNT_MAX      = {CNT_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0] CNT_ONE      = 1;
   localparam logic [CNT_BITS-1:0] TIMEOUT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
   localparam logic [DW-1:0]       DRAIN_INIT   = DW'(DRAIN_CYCLES);
   localparam logic [DW-1:0]       DRAIN_ONE    = 1;
   localparam logic [AW:0]         PTR_ONE      = 1;
   localparam logic [AW-1:0]       IDX_ONE      = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [DW-1:0]     drain_cnt, drain_nxt;
   logic              timeout_r, timeout_nxt;
   logic              halt, timed_out, active;

   logic [CNT_BITS-1:0] cycle_cnt, inst_cnt, drop_cnt;
   logic                overflow_r;

   logic [EW-1:0]     mem [TRACE_DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic [AW-1:0]     head_idx;
   logic              empty, full, push_req, push, pop, drop;

   // ---------------- run/halt FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         drain_cnt <= '0;
         timeout_r <= 1'b0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_nxt;
         timeout_r <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      drain_nxt   = drain_cnt;
      timeout_nxt = timeout_r;
      halt        = inst_valid && (inst_word_in == HALT_WORD);
      timed_out   = (TIMEOUT_CYCLES != 0) && (cycle_cnt == TIMEOUT_LAST);
      case (state)
         S_IDLE: if (enable) state_nxt = S_RUN;
         S_RUN: begin
            // A halt on the timeout edge wins, so the timeout flag stays clear.
            if (halt) begin
               if (DRAIN_CYCLES == 0) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_DRAIN;
                  drain_nxt = DRAIN_INIT;
               end
            end else if (timed_out) begin
               state_nxt   = S_DONE;
               timeout_nxt = 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_cnt == DRAIN_ONE) state_nxt = S_DONE;
            else                        drain_nxt = drain_cnt - DRAIN_ONE;
         end
         default: ;
      endcase
      if (clear) begin
         state_nxt   = S_IDLE;
         drain_nxt   = '0;
         timeout_nxt = 1'b0;
      end
   end

   assign active = (state == S_RUN) || (state == S_DRAIN);

   // ---------------- saturating run counters ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt <= '0;
         inst_cnt  <= '0;
      end else if (clear) begin
         cycle_cnt <= '0;
         inst_cnt  <= '0;
      end else if (active) begin
         if (cycle_cnt != CNT_MAX)              cycle_cnt <= cycle_cnt + CNT_ONE;
         if (inst_valid && inst_cnt != CNT_MAX) inst_cnt  <= inst_cnt + CNT_ONE;
      end
   end

   // ---------------- writeback trace FIFO ----------------
   // Handshake: the head entry transfers on any edge where trace_valid && trace_ready;
   // while trace_valid is high and trace_ready low the head fields do not change.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop      = !empty && trace_ready;
   assign push_req = wb_en && active;
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_r <= 1'b0;
         drop_cnt   <= '0;
         for (int i = 0; i < TRACE_DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_r <= 1'b0;
         drop_cnt   <= '0;
         for (int i = 0; i < TRACE_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= {pc_in, wb_reg, wb_data};
            wr_ptr              <= wr_ptr + PTR_ONE;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         if (drop) begin
            overflow_r <= 1'b1;
            if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + CNT_ONE;
         end
      end
   end

   // When empty, the slot just behind the read pointer still holds the last popped entry.
   assign head_idx = empty ? (rd_ptr[AW-1:0] - IDX_ONE) : rd_ptr[AW-1:0];
   assign {trace_pc, trace_reg, trace_data} = mem[head_idx];

   assign trace_valid    = !empty;
   assign trace_overflow = overflow_r;
   assign drop_count     = drop_cnt;
   assign cycle_count    = cycle_cnt;
   assign inst_count     = inst_cnt;
   assign state_out      = state;
   assign done           = (state == S_DONE);
   assign timeout        = timeout_r;

endmodule

// File: tb/tb_proc_run_monitor.sv
// Bench for proc_run_monitor: two instances (22-edge drain with 50-cycle timeout, and zero drain
// without timeout) share random stimulus and are checked every cycle against a queue-based model.
module tb_proc_run_monitor;

   localparam int          EW    = 68;
   localparam int          DEPTH = 16;
   localparam logic [31:0] HALT  = 32'h0000DEAD;
   localparam longint      CMAX  = 64'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset, enable, clear, inst_valid, wb_en, trace_ready;
   logic [31:0] inst_word_in, pc_in, wb_data;
   logic [3:0]  wb_reg;

   logic        a_valid, a_ovf, a_done, a_to, b_valid, b_ovf, b_done, b_to;
   logic [31:0] a_pc, a_data, a_drop, a_cyc, a_inst, b_pc, b_data, b_drop, b_cyc, b_inst;
   logic [3:0]  a_reg, b_reg;
   logic [1:0]  a_state, b_state;

   int n_cmp = 0;
   int n_err = 0;
   int pops;

   // reference model: abstract state number 0..3, drain countdown, counters and trace queues
   int       p_drain [2] = '{22, 0};
   int       p_to    [2] = '{50, 0};
   int       m_state [2];
   int       m_dcnt  [2];
   longint   m_cyc   [2];
   longint   m_inst  [2];
   longint   m_drop  [2];
   bit       m_ovf   [2];
   bit       m_to    [2];
   logic [EW-1:0] m_last [2];
   logic [EW-1:0] exp_q0 [$];
   logic [EW-1:0] exp_q1 [$];

   proc_run_monitor #(.DRAIN_CYCLES(22), .TIMEOUT_CYCLES(50), .TRACE_DEPTH(DEPTH)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .inst_valid(inst_valid), .inst_word_in(inst_word_in), .pc_in(pc_in),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
      .trace_valid(a_valid), .trace_ready(trace_ready), .trace_pc(a_pc),
      .trace_reg(a_reg), .trace_data(a_data), .trace_overflow(a_ovf),
      .drop_count(a_drop), .cycle_count(a_cyc), .inst_count(a_inst),
      .state_out(a_state), .done(a_done), .timeout(a_to)
   );

   proc_run_monitor #(.DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0), .TRACE_DEPTH(DEPTH)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .inst_valid(inst_valid), .inst_word_in(inst_word_in), .pc_in(pc_in),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
      .trace_valid(b_valid), .trace_ready(trace_ready), .trace_pc(b_pc),
      .trace_reg(b_reg), .trace_data(b_data), .trace_overflow(b_ovf),
      .drop_count(b_drop), .cycle_count(b_cyc), .inst_count(b_inst),
      .state_out(b_state), .done(b_done), .timeout(b_to)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint sat_inc(input longint v);
      return (v >= CMAX) ? v : v + 1;
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = w ^ 32'h1;
      return w;
   endfunction

   task automatic model_reset(input int i);
      m_state[i] = 0;
      m_dcnt[i]  = 0;
      m_cyc[i]   = 0;
      m_inst[i]  = 0;
      m_drop[i]  = 0;
      m_ovf[i]   = 1'b0;
      m_to[i]    = 1'b0;
      m_last[i]  = '0;
      if (i == 0) exp_q0.delete();
      else        exp_q1.delete();
   endtask

   // advance model instance i across one rising edge using the currently driven inputs
   task automatic model_edge(input int i);
      logic [EW-1:0] ent;
      int sz;
      bit halt, act;
      if (clear) begin
         model_reset(i);
         return;
      end
      ent = {pc_in, wb_reg, wb_data};
      sz  = (i == 0) ? exp_q0.size() : exp_q1.size();
      act = (m_state[i] == 1) || (m_state[i] == 2);
      if (sz > 0 && trace_ready) begin
         if (i == 0) m_last[i] = exp_q0.pop_front();
         else        m_last[i] = exp_q1.pop_front();
         sz--;
      end
      if (act && wb_en) begin
         if (sz < DEPTH) begin
            if (i == 0) exp_q0.push_back(ent);
            else        exp_q1.push_back(ent);
         end else begin
            m_ovf[i]  = 1'b1;
            m_drop[i] = sat_inc(m_drop[i]);
         end
      end
      halt = inst_valid && (inst_word_in == HALT);
      if (act && inst_valid) m_inst[i] = sat_inc(m_inst[i]);
      case (m_state[i])
         0: if (enable) m_state[i] = 1;
         1: begin
            if (halt) begin
               if (p_drain[i] == 0) m_state[i] = 3;
               else begin
                  m_state[i] = 2;
                  m_dcnt[i]  = p_drain[i];
               end
            end else if (p_to[i] != 0 && m_cyc[i] == longint'(p_to[i] - 1)) begin
               m_state[i] = 3;
               m_to[i]    = 1'b1;
            end
         end
         2: begin
            if (m_dcnt[i] == 1) m_state[i] = 3;
            else                m_dcnt[i]  = m_dcnt[i] - 1;
         end
         default: ;
      endcase
      if (act) m_cyc[i] = sat_inc(m_cyc[i]);
   endtask

   task automatic check_inst(input int i, input logic tv, input logic [31:0] tpc,
                             input logic [3:0] treg, input logic [31:0] tdata, input logic tovf,
                             input logic [31:0] drop, input logic [31:0] cyc, input logic [31:0] inst,
                             input logic [1:0] st, input logic dn, input logic to);
      logic [EW-1:0] head;
      int sz;
      string p;
      p  = (i == 0) ? "a" : "b";
      sz = (i == 0) ? exp_q0.size() : exp_q1.size();
      if (sz > 0) head = (i == 0) ? exp_q0[0] : exp_q1[0];
      else        head = m_last[i];
      check({p, "_state"},    64'(st),    64'(m_state[i]));
      check({p, "_done"},     64'(dn),    64'(m_state[i] == 3));
      check({p, "_timeout"},  64'(to),    64'(m_to[i]));
      check({p, "_cycles"},   64'(cyc),   64'(m_cyc[i]));
      check({p, "_insts"},    64'(inst),  64'(m_inst[i]));
      check({p, "_drops"},    64'(drop),  64'(m_drop[i]));
      check({p, "_overflow"}, 64'(tovf),  64'(m_ovf[i]));
      check({p, "_tvalid"},   64'(tv),    64'(sz > 0));
      check({p, "_head"},     64'({tpc, treg, tdata}), 64'(head));
   endtask

   task automatic check_all();
      check_inst(0, a_valid, a_pc, a_reg, a_data, a_ovf, a_drop, a_cyc, a_inst, a_state, a_done, a_to);
      check_inst(1, b_valid, b_pc, b_reg, b_data, b_ovf, b_drop, b_cyc, b_inst, b_state, b_done, b_to);
   endtask

   // ---------------- driver ----------------
   // called at a falling edge: drive, predict, cross one rising edge, compare at the next falling edge
   task automatic step(input logic en, input logic clr, input logic iv, input logic [31:0] iw,
                       input logic we, input logic rdy);
      enable       = en;
      clear        = clr;
      inst_valid   = iv;
      inst_word_in = iw;
      wb_en        = we;
      trace_ready  = rdy;
      pc_in        = $urandom;
      wb_reg       = 4'($urandom_range(0, 15));
      wb_data      = $urandom;
      model_edge(0);
      model_edge(1);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b0; enable = 1'b0; clear = 1'b0; inst_valid = 1'b0; inst_word_in = '0;
      pc_in = '0; wb_en = 1'b0; wb_reg = '0; wb_data = '0; trace_ready = 1'b0;
      #1 reset = 1'b1;
      model_reset(0);
      model_reset(1);
      repeat (2) @(negedge clk);
      check_all();
      reset = 1'b0;

      // halt at RUN cycle 10, 22-edge drain, second halt mid-drain ignored
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) step(1'b0, 1'b0, rbit(), rand_word(), rbit(), rbit());
      check("t1_cycles_at_halt", 64'(a_cyc), 64'd10);
      step(1'b0, 1'b0, 1'b1, HALT, 1'b1, rbit());
      check("t1_a_in_drain", 64'(a_state), 64'd2);
      check("t6_b_done_next_edge", 64'(b_done), 64'd1);
      for (int k = 0; k < 21; k++)
         step(1'b0, 1'b0, (k == 4) ? 1'b1 : rbit(), (k == 4) ? HALT : rand_word(), rbit(), rbit());
      check("t1_not_done_at_21", 64'(a_done), 64'd0);
      step(1'b0, 1'b0, 1'b1, HALT, rbit(), rbit());
      check("t1_done_at_22", 64'(a_done), 64'd1);
      check("t1_no_timeout", 64'(a_to), 64'd0);
      check("t1_cycles_total", 64'(a_cyc), 64'd33);
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, rbit(), rand_word(), 1'b1, 1'b1);

      // timeout after the cycle_count==49 edge
      step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 49; k++) step(1'b0, 1'b0, rbit(), rand_word(), rbit(), rbit());
      check("t2_still_run", 64'(a_state), 64'd1);
      step(1'b0, 1'b0, rbit(), rand_word(), rbit(), rbit());
      check("t2_done", 64'(a_done), 64'd1);
      check("t2_timeout", 64'(a_to), 64'd1);
      check("t2_cycles", 64'(a_cyc), 64'd50);

      // halt on the timeout edge wins
      step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 49; k++) step(1'b0, 1'b0, rbit(), rand_word(), rbit(), rbit());
      step(1'b0, 1'b0, 1'b1, HALT, rbit(), rbit());
      check("t2_halt_wins_state", 64'(a_state), 64'd2);
      check("t2_halt_wins_timeout", 64'(a_to), 64'd0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, rbit(), rand_word(), 1'b1, 1'b0);

      // asynchronous reset between edges, mid-drain
      #2 reset = 1'b1;
      #1;
      model_reset(0);
      model_reset(1);
      check("t5_state_at_once", 64'(a_state), 64'd0);
      check("t5_tvalid_at_once", 64'(a_valid), 64'd0);
      check_all();
      @(posedge clk);
      @(negedge clk);
      check_all();
      reset = 1'b0;

      // overflow: 20 writebacks with no consumer, then push+pop on a full FIFO
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) step(1'b0, 1'b0, rbit(), rand_word(), 1'b1, 1'b0);
      check("t3_drops", 64'(a_drop), 64'd4);
      check("t3_overflow", 64'(a_ovf), 64'd1);
      step(1'b0, 1'b0, rbit(), rand_word(), 1'b1, 1'b1);
      check("t4_no_new_drop", 64'(a_drop), 64'd4);
      pops = 0;
      for (int k = 0; k < 20; k++) begin
         if (a_valid) pops++;
         step(1'b0, 1'b0, rbit(), rand_word(), 1'b0, 1'b1);
      end
      check("t4_entries_popped", 64'(pops), 64'd16);

      // random soak
      for (int r = 0; r < 4; r++) begin
         step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
         step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
         for (int k = 0; k < 150; k++)
            step(rbit(), ($urandom_range(0, 99) == 0), rbit(),
                 ($urandom_range(0, 29) == 0) ? HALT : rand_word(),
                 rbit(), ($urandom_range(0, 3) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
